// File: rtl/gate_accumulator.sv
// gate_accumulator: registered bitwise gate (AND/OR/XOR/NAND) with a
// valid/ready interface. Single mode emits one result per beat; accumulate
// mode folds a multi-beat packet into one result emitted after the last beat.
// Optional feature macro: GATE_ACCUMULATOR_PARITY_EN adds out_parity, the
// XOR-reduce of out_f, registered and held alongside it.
module gate_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic [CNT_W-1:0] out_beats
`ifdef GATE_ACCUMULATOR_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_mode;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_f;
    logic [CNT_W-1:0] r_out_beats;

    logic             w_idle;
    logic             w_accept;
    logic             w_take;
    logic [1:0]       w_op_eff;
    logic [WIDTH-1:0] w_beat;
    logic [WIDTH-1:0] w_fold;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_complete;
    logic [WIDTH-1:0] w_result;
    logic [CNT_W-1:0] w_res_beats;

    assign w_idle    = (r_state == ST_IDLE);
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_take    = r_out_valid && out_ready;

    // Inside a packet the op latched on the first beat governs every beat.
    assign w_op_eff  = w_idle ? in_op : r_op;

    // Per-beat value; NAND keeps the un-inverted AND so the fold stays associative.
    always_comb begin
        case (w_op_eff)
            OP_OR:   w_beat = in_a | in_b;
            OP_XOR:  w_beat = in_a ^ in_b;
            default: w_beat = in_a & in_b;
        endcase
    end

    // Combine the running accumulator with the current beat.
    always_comb begin
        case (r_op)
            OP_OR:   w_fold = r_acc | w_beat;
            OP_XOR:  w_fold = r_acc ^ w_beat;
            default: w_fold = r_acc & w_beat;
        endcase
    end

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    // A beat completes a result in IDLE unless it opens a packet; in ACCUM only on last.
    assign w_complete = w_accept &&
                        (w_idle ? (!in_acc || in_last) : (in_last && r_mode));

    // Final result: invert only at emission time for NAND.
    always_comb begin
        if (w_idle) begin
            w_result    = (in_op == OP_NAND) ? ~w_beat : w_beat;
            w_res_beats = CNT_ONE;
        end else begin
            w_result    = (r_op == OP_NAND) ? ~w_fold : w_fold;
            w_res_beats = w_cnt_inc;
        end
    end

    // Packet state machine, accumulator, beat counter and latched op/mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= OP_AND;
            r_mode  <= 1'b0;
        end else if (w_accept) begin
            if (w_idle) begin
                r_op   <= in_op;
                r_mode <= in_acc;
                if (in_acc && !in_last) begin
                    r_acc   <= w_beat;
                    r_cnt   <= CNT_ONE;
                    r_state <= ST_ACCUM;
                end
            end else if (w_complete) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= ST_IDLE;
            end else begin
                r_acc <= w_fold;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Output register: load on completion (even during a take), clear valid on a bare take.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_f     <= '0;
            r_out_beats <= '0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_f     <= w_result;
            r_out_beats <= w_res_beats;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_f     = r_out_f;
    assign out_beats = r_out_beats;

`ifdef GATE_ACCUMULATOR_PARITY_EN
    logic r_parity;

    // Parity travels with out_f and is held with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_complete) begin
            r_parity <= ^w_result;
        end
    end

    assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_gate_accumulator.sv
// Self-checking bench for gate_accumulator (WIDTH=8, CNT_W=4): directed
// scenarios followed by randomized traffic, checked by a scoreboard fed from
// a list-based packet model.
module tb_gate_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic       in_acc;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_f;
    logic [3:0] out_beats;
`ifdef GATE_ACCUMULATOR_PARITY_EN
    logic       out_parity;
`endif

    gate_accumulator #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_beats (out_beats)
`ifdef GATE_ACCUMULATOR_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic [3:0] beats;
    } result_t;

    result_t    exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    // Reference model state: the packet is kept as a list of beat values.
    bit         m_in_pkt = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_vals[$];
    bit         exp_valid_next = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] beat_val(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Fold the whole packet list in one go, then apply the NAND inversion.
    function automatic result_t fold_packet(input logic [1:0] op, input logic [7:0] vals[$]);
        result_t    r;
        logic [7:0] x;
        x = vals[0];
        for (int i = 1; i < vals.size(); i++) begin
            if (op == 2'd1)      x = x | vals[i];
            else if (op == 2'd2) x = x ^ vals[i];
            else                 x = x & vals[i];
        end
        r.f     = (op == 2'd3) ? ~x : x;
        r.beats = (vals.size() > 15) ? 4'd15 : 4'(vals.size());
        return r;
    endfunction

    // Monitor: samples on the falling edge what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_vals.delete();
            m_in_pkt       = 1'b0;
            exp_valid_next = 1'b0;
        end else begin
            if (exp_valid_next) begin
                chk(out_valid == 1'b1, "latency_valid", 32'(out_valid), 32'd1);
                exp_valid_next = 1'b0;
            end
            chk(in_ready == (!out_valid || out_ready), "in_ready_rule", 32'(in_ready),
                32'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_valid", 32'(out_f), 32'd0);
                end else begin
                    chk(out_f == exp_q[0].f, "out_f", 32'(out_f), 32'(exp_q[0].f));
                    chk(out_beats == exp_q[0].beats, "out_beats", 32'(out_beats), 32'(exp_q[0].beats));
`ifdef GATE_ACCUMULATOR_PARITY_EN
                    chk(out_parity == ^exp_q[0].f, "out_parity", 32'(out_parity), 32'(^exp_q[0].f));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                logic [7:0] v;
                v = beat_val(in_a, in_b, m_in_pkt ? m_op : in_op);
                if (!m_in_pkt) begin
                    m_op = in_op;
                    m_vals.delete();
                    m_vals.push_back(v);
                    if (!in_acc || in_last) begin
                        exp_q.push_back(fold_packet(m_op, m_vals));
                        exp_valid_next = 1'b1;
                        m_vals.delete();
                    end else begin
                        m_in_pkt = 1'b1;
                    end
                end else begin
                    m_vals.push_back(v);
                    if (in_last) begin
                        exp_q.push_back(fold_packet(m_op, m_vals));
                        exp_valid_next = 1'b1;
                        m_vals.delete();
                        m_in_pkt = 1'b0;
                    end
                end
            end
        end
    end

    // Present one beat and hold it until accepted; reports cycles spent stalled.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic acc, input logic last, output int stalls);
        int k;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
        in_last  = last;
        k        = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) chk(1'b0, "send_timeout", 32'(k), 32'd0);
        stalls = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int st;
        int total_st;
        logic [7:0] sweep_res[4];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
        chk(out_f == 8'h00, "reset_out_f", 32'(out_f), 32'd0);
        chk(out_beats == 4'd0, "reset_out_beats", 32'(out_beats), 32'd0);
        chk(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single-mode truth sweep, back to back, never stalled.
        total_st = 0;
        for (int op = 0; op < 4; op++) begin
            send(8'hF0, 8'hCC, 2'(op), 1'b0, 1'b0, st);
            total_st += st;
        end
        chk(total_st == 0, "sweep_no_stall", 32'(total_st), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Accumulate AND, 3 beats; no result while the packet is open.
        send(8'hFF, 8'hF7, 2'd0, 1'b1, 1'b0, st);
        chk(out_valid == 1'b0, "acc_and_no_valid_b1", 32'(out_valid), 32'd0);
        send(8'hFE, 8'hFF, 2'd0, 1'b1, 1'b0, st);
        chk(out_valid == 1'b0, "acc_and_no_valid_b2", 32'(out_valid), 32'd0);
        send(8'h7F, 8'hFF, 2'd0, 1'b1, 1'b1, st);
        repeat (2) @(posedge clk);
        #1;

        // Accumulate NAND, 2 beats; the op change on beat 2 must be ignored.
        send(8'h0F, 8'hFF, 2'd3, 1'b1, 1'b0, st);
        send(8'hFF, 8'h3C, 2'd1, 1'b0, 1'b1, st);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: pending result blocks the next beat for 5 cycles.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 2'd2, 1'b0, 1'b0, st);
        in_valid = 1'b1;
        in_a     = 8'h5A;
        in_b     = 8'h0F;
        in_op    = 2'd1;
        in_acc   = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(in_ready == 1'b0, "bp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Saturation: 20-beat XOR packet.
        for (int i = 0; i < 20; i++) begin
            send(8'h01, 8'h00, 2'd2, 1'b1, (i == 19), st);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset discards a pending result.
        out_ready = 1'b0;
        send(8'h0F, 8'hF0, 2'd1, 1'b0, 1'b0, st);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "rst_pend_out_valid", 32'(out_valid), 32'd0);
        chk(out_f == 8'h00, "rst_pend_out_f", 32'(out_f), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Reset mid-packet, then a single XOR beat.
        send(8'hFF, 8'h0F, 2'd0, 1'b1, 1'b0, st);
        send(8'hF3, 8'hFF, 2'd0, 1'b1, 1'b0, st);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk(out_f == 8'h00, "rst_mid_out_f", 32'(out_f), 32'd0);
        chk(out_beats == 4'd0, "rst_mid_out_beats", 32'(out_beats), 32'd0);
        @(posedge clk);
        #1;
        send(8'hAA, 8'h55, 2'd2, 1'b0, 1'b0, st);
        repeat (2) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and occasional reset.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_op     = 2'($urandom_range(0, 3));
            in_acc    = 1'($urandom_range(0, 1));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
